// File: rtl/seg_scan_disp.sv
// Multiplexed 7-segment scanner with double-buffered digit data, a per-slot brightness window,
// and an anti-ghost dead band. Define HEX_LZB_EN to blank leading zero digits.
module seg_scan_disp #(
  parameter int DIGITS          = 8,
  parameter int SCAN_DIV        = 50000,
  parameter int BLANK_CYC       = 500,
  parameter int SEL_ACTIVE_HIGH = 1,
  parameter int SEG_ACTIVE_LOW  = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     sel,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic                  frame_done
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [25:0] BLANK_W = 26'(BLANK_CYC);
  localparam logic [25:0] SPAN_W  = 26'(SCAN_DIV - BLANK_CYC);
  localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_HIGH != 0) ? '0 : '1;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  logic [SW-1:0]       slot_q, slot_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shd_data_q, shd_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic [3:0]          bright_q, bright_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [6:0]          seg_q, seg_d;
  logic                seg_dp_q, seg_dp_d;
  logic                frame_done_q, frame_done_d;

  logic                frame_end;
  logic [25:0]         on_len;
  logic                in_win, show;
  logic [DIGITS-1:0]   onehot, blank;
  logic [3:0]          nib;
  logic                dp_bit, blk;
  logic [6:0]          seg_raw;
`ifdef HEX_LZB_EN
  logic                lzb_run;
`endif

  always_comb begin
    frame_end = En && (slot_q == SLOT_LAST) && (idx_q == IDX_LAST);

    slot_d = slot_q;
    idx_d  = idx_q;
    if (!En) begin
      slot_d = '0;
      idx_d  = '0;
    end else if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end else begin
      slot_d = slot_q + SW'(1);
    end

    shd_data_d = load ? disp_data : shd_data_q;
    shd_dp_d   = load ? dp : shd_dp_q;

    // A load landing on the frame boundary bypasses the shadow so it is not lost for a frame.
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    if (!En) begin
      act_data_d = shd_data_q;
      act_dp_d   = shd_dp_q;
    end else if (frame_end) begin
      act_data_d = load ? disp_data : shd_data_q;
      act_dp_d   = load ? dp : shd_dp_q;
    end

    bright_d = (slot_q == '0) ? bright : bright_q;
    on_len   = (SPAN_W * (26'(bright_d) + 26'd1)) >> 4;
    in_win   = (26'(slot_q) >= BLANK_W) && (26'(slot_q) < BLANK_W + on_len);
    show     = En && in_win;

    onehot = '0;
    nib    = 4'h0;
    dp_bit = 1'b0;
    blk    = 1'b0;
    blank  = '0;
`ifdef HEX_LZB_EN
    lzb_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lzb_run && (act_data_q[4*k +: 4] == 4'h0) && !act_dp_q[k]) blank[k] = 1'b1;
      else lzb_run = 1'b0;
    end
`endif
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        onehot[k] = 1'b1;
        nib       = act_data_q[4*k +: 4];
        dp_bit    = act_dp_q[k];
        blk       = blank[k];
      end
    end
    seg_raw = blk ? 7'h00 : hex_to_seg(nib);

    sel_d        = show ? ((SEL_ACTIVE_HIGH != 0) ? onehot : ~onehot) : SEL_OFF;
    seg_d        = show ? ((SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw) : SEG_OFF;
    seg_dp_d     = show ? ((SEG_ACTIVE_LOW != 0) ? ~dp_bit : dp_bit) : DP_OFF;
    frame_done_d = frame_end;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      slot_q       <= '0;
      idx_q        <= '0;
      shd_data_q   <= '0;
      shd_dp_q     <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      bright_q     <= '0;
      sel_q        <= SEL_OFF;
      seg_q        <= SEG_OFF;
      seg_dp_q     <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      shd_data_q   <= shd_data_d;
      shd_dp_q     <= shd_dp_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      bright_q     <= bright_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign frame_done = frame_done_q;

endmodule
